game_sequencer: RTL and testbench

Top-level play sequencer for the breakout game. It owns the game state, lives, the BCD score and the ball speed phase. It serves the ball after a frame-counted delay and issues reset pulses to the ball/paddle and block-grid datapath. It sits between the button inputs and the ball/block datapath, which reports block_hit and ball_lost events back to it.

---
 rtl/game_sequencer_if.sv | 29 ++
 rtl/game_sequencer.sv | 146 ++++++++++++++
 tb/tb_game_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Button/event inputs and status/control outputs of the breakout play sequencer.
interface game_sequencer_if;
    logic       frame_tick;
    logic       start;
    logic       block_hit;
    logic       ball_lost;
    logic [2:0] state;
    logic       ball_run;
    logic       ball_reset;
    logic       field_reset;
    logic [1:0] ball_speed;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic [3:0] lives;
    logic       game_won;
    logic       game_over;

    modport master (
        output frame_tick, start, block_hit, ball_lost,
        input  state, ball_run, ball_reset, field_reset, ball_speed,
               score_ones, score_tens, lives, game_won, game_over
    );

    modport slave (
        input  frame_tick, start, block_hit, ball_lost,
        output state, ball_run, ball_reset, field_reset, ball_speed,
               score_ones, score_tens, lives, game_won, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Breakout play sequencer: game state, lives, BCD score, serve delay and speed phase.
// All outputs registered, one clk from input to output; no backpressure, every pulse is consumed.
module game_sequencer #(
    parameter int START_LIVES = 3,
    parameter int SERVE_DELAY = 60,
    parameter int PHASE2_TENS = 2,
    parameter int PHASE3_TENS = 4,
    parameter int WIN_TENS    = 6
) (
    input  logic             clk,
    input  logic             rst,
    game_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_WIN   = 3'd3;
    localparam logic [2:0] S_LOSE  = 3'd4;

    logic [2:0] state_q,  state_d;
    logic [3:0] ones_q,   ones_d;
    logic [3:0] tens_q,   tens_d;
    logic [3:0] lives_q,  lives_d;
    logic [7:0] cnt_q,    cnt_d;
    logic       ball_reset_q, ball_reset_d;
    logic       field_reset_q, field_reset_d;
    logic [1:0] speed_q,  speed_d;
    logic       run_q, won_q, over_q;

    always_comb begin
        state_d       = state_q;
        ones_d        = ones_q;
        tens_d        = tens_q;
        lives_d       = lives_q;
        cnt_d         = cnt_q;
        ball_reset_d  = 1'b0;
        field_reset_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                ones_d  = 4'd0;
                tens_d  = 4'd0;
                lives_d = 4'(START_LIVES);
                if (bus.start) begin
                    state_d       = S_SERVE;
                    cnt_d         = 8'(SERVE_DELAY);
                    ball_reset_d  = 1'b1;
                    field_reset_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (cnt_q == 8'd0) state_d = S_PLAY;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            S_PLAY: begin
                if (bus.block_hit) begin
                    if (ones_q == 4'd9) begin
                        if (tens_q != 4'd9) begin
                            ones_d = 4'd0;
                            tens_d = tens_q + 4'd1;
                        end
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
                // A win on this hit takes priority over a simultaneous ball loss.
                if (bus.block_hit && tens_d == 4'(WIN_TENS) && ones_d == 4'd0) begin
                    state_d = S_WIN;
                end else if (bus.ball_lost) begin
                    lives_d = lives_q - 4'd1;
                    if (lives_q == 4'd1) begin
                        state_d = S_LOSE;
                    end else begin
                        state_d      = S_SERVE;
                        cnt_d        = 8'(SERVE_DELAY);
                        ball_reset_d = 1'b1;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (bus.start) begin
                    state_d       = S_SERVE;
                    ones_d        = 4'd0;
                    tens_d        = 4'd0;
                    lives_d       = 4'(START_LIVES);
                    cnt_d         = 8'(SERVE_DELAY);
                    ball_reset_d  = 1'b1;
                    field_reset_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ones_d  = 4'd0;
                tens_d  = 4'd0;
                lives_d = 4'(START_LIVES);
                cnt_d   = 8'd0;
            end
        endcase

        // Speed follows the post-update score so a phase change lands with the score change.
        if (state_d != S_PLAY)                speed_d = 2'd0;
        else if (tens_d < 4'(PHASE2_TENS))    speed_d = 2'd1;
        else if (tens_d < 4'(PHASE3_TENS))    speed_d = 2'd2;
        else                                  speed_d = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
            lives_q       <= 4'(START_LIVES);
            cnt_q         <= 8'd0;
            ball_reset_q  <= 1'b0;
            field_reset_q <= 1'b0;
            speed_q       <= 2'd0;
            run_q         <= 1'b0;
            won_q         <= 1'b0;
            over_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            lives_q       <= lives_d;
            cnt_q         <= cnt_d;
            ball_reset_q  <= ball_reset_d;
            field_reset_q <= field_reset_d;
            speed_q       <= speed_d;
            run_q         <= (state_d == S_PLAY);
            won_q         <= (state_d == S_WIN);
            over_q        <= (state_d == S_LOSE);
        end
    end

    assign bus.state       = state_q;
    assign bus.ball_run    = run_q;
    assign bus.ball_reset  = ball_reset_q;
    assign bus.field_reset = field_reset_q;
    assign bus.ball_speed  = speed_q;
    assign bus.score_ones  = ones_q;
    assign bus.score_tens  = tens_q;
    assign bus.lives       = lives_q;
    assign bus.game_won    = won_q;
    assign bus.game_over   = over_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer with a score-as-integer reference model and directed pins.
module tb_game_sequencer;
    localparam int START_LIVES = 3;
    localparam int SERVE_DELAY = 60;
    localparam int PHASE2_TENS = 2;
    localparam int PHASE3_TENS = 4;
    localparam int WIN_TENS    = 6;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_WIN = 3, M_LOSE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    game_sequencer_if gif();

    game_sequencer dut (.clk(clk), .rst(rst), .bus(gif));

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit cmp_en = 1'b0;

    // Reference model: score kept as a plain integer, serve measured in ticks seen.
    int m_state, m_score, m_lives, m_ticks;
    bit m_br, m_fr;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_br = 1'b0;
        m_fr = 1'b0;
        if (rst) begin
            m_state = M_IDLE; m_score = 0; m_lives = START_LIVES; m_ticks = 0;
            return;
        end
        case (m_state)
            M_IDLE: begin
                m_score = 0; m_lives = START_LIVES;
                if (gif.start) begin
                    m_state = M_SERVE; m_ticks = 0; m_br = 1'b1; m_fr = 1'b1;
                end
            end
            M_SERVE: begin
                if (gif.frame_tick) begin
                    m_ticks++;
                    if (m_ticks == SERVE_DELAY + 1) m_state = M_PLAY;
                end
            end
            M_PLAY: begin
                if (gif.block_hit && m_score < 99) m_score++;
                if (gif.block_hit && m_score == WIN_TENS * 10) begin
                    m_state = M_WIN;
                end else if (gif.ball_lost) begin
                    if (m_lives == 1) begin
                        m_lives = 0; m_state = M_LOSE;
                    end else begin
                        m_lives--; m_state = M_SERVE; m_ticks = 0; m_br = 1'b1;
                    end
                end
            end
            default: begin
                if (gif.start) begin
                    m_state = M_SERVE; m_score = 0; m_lives = START_LIVES; m_ticks = 0;
                    m_br = 1'b1; m_fr = 1'b1;
                end
            end
        endcase
    endtask

    function automatic int model_speed();
        if (m_state != M_PLAY)               return 0;
        if (m_score / 10 < PHASE2_TENS)      return 1;
        if (m_score / 10 < PHASE3_TENS)      return 2;
        return 3;
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("cmp_state",       int'(gif.state),       m_state);
            chk("cmp_ball_run",    int'(gif.ball_run),    int'(m_state == M_PLAY));
            chk("cmp_ball_reset",  int'(gif.ball_reset),  int'(m_br));
            chk("cmp_field_reset", int'(gif.field_reset), int'(m_fr));
            chk("cmp_ball_speed",  int'(gif.ball_speed),  model_speed());
            chk("cmp_score_ones",  int'(gif.score_ones),  m_score % 10);
            chk("cmp_score_tens",  int'(gif.score_tens),  m_score / 10);
            chk("cmp_lives",       int'(gif.lives),       m_lives);
            chk("cmp_game_won",    int'(gif.game_won),    int'(m_state == M_WIN));
            chk("cmp_game_over",   int'(gif.game_over),   int'(m_state == M_LOSE));
        end
    end

    // One clock: inputs applied at negedge, sampled at posedge, released just after.
    task automatic step(bit rs, bit st, bit ft, bit bh, bit bl);
        @(negedge clk);
        rst = rs; gif.start = st; gif.frame_tick = ft; gif.block_hit = bh; gif.ball_lost = bl;
        @(posedge clk);
        #1;
        rst = 1'b0; gif.start = 1'b0; gif.frame_tick = 1'b0; gif.block_hit = 1'b0; gif.ball_lost = 1'b0;
    endtask

    task automatic serve_through();
        for (int i = 0; i < SERVE_DELAY + 1; i++) step(0, 0, 1, 0, 0);
    endtask

    task automatic hits(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
    endtask

    initial begin
        gif.start = 1'b0; gif.frame_tick = 1'b0; gif.block_hit = 1'b0; gif.ball_lost = 1'b0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        cmp_en = 1'b1;
        chk("rst_state", int'(gif.state), 0);
        chk("rst_lives", int'(gif.lives), 3);
        chk("rst_speed", int'(gif.ball_speed), 0);

        step(0, 1, 1, 0, 0);
        chk("start_state", int'(gif.state), 1);
        chk("start_ball_reset", int'(gif.ball_reset), 1);
        chk("start_field_reset", int'(gif.field_reset), 1);
        step(0, 0, 0, 0, 0);
        chk("pulse_one_clk", int'(gif.ball_reset), 0);
        for (int i = 0; i < SERVE_DELAY; i++) step(0, 0, 1, 0, 0);
        chk("serve_60_ticks", int'(gif.state), 1);
        step(0, 0, 1, 0, 0);
        chk("play_state", int'(gif.state), 2);
        chk("play_run", int'(gif.ball_run), 1);
        chk("play_speed1", int'(gif.ball_speed), 1);

        hits(19);
        chk("score19_ones", int'(gif.score_ones), 9);
        chk("score19_tens", int'(gif.score_tens), 1);
        hits(1);
        chk("score20_tens", int'(gif.score_tens), 2);
        chk("score20_speed", int'(gif.ball_speed), 2);
        hits(20);
        chk("score40_speed", int'(gif.ball_speed), 3);

        step(0, 0, 0, 0, 1);
        chk("lost1_lives", int'(gif.lives), 2);
        chk("lost1_state", int'(gif.state), 1);
        chk("lost1_ball_reset", int'(gif.ball_reset), 1);
        chk("lost1_field_reset", int'(gif.field_reset), 0);
        serve_through();
        step(0, 0, 0, 0, 1);
        chk("lost2_lives", int'(gif.lives), 1);
        serve_through();
        step(0, 0, 0, 0, 1);
        chk("lost3_state", int'(gif.state), 4);
        chk("lost3_lives", int'(gif.lives), 0);
        chk("lost3_over", int'(gif.game_over), 1);
        chk("lost3_run", int'(gif.ball_run), 0);

        step(0, 1, 0, 0, 0);
        chk("restart_state", int'(gif.state), 1);
        chk("restart_lives", int'(gif.lives), 3);
        chk("restart_field_reset", int'(gif.field_reset), 1);
        step(0, 0, 0, 1, 0);
        chk("serve_hit_ignored", int'(gif.score_ones), 0);
        serve_through();
        hits(59);
        step(0, 0, 0, 0, 1);
        serve_through();
        step(0, 0, 0, 0, 1);
        serve_through();
        step(0, 0, 0, 1, 1);
        chk("win_state", int'(gif.state), 3);
        chk("win_tens", int'(gif.score_tens), 6);
        chk("win_ones", int'(gif.score_ones), 0);
        chk("win_lives", int'(gif.lives), 1);
        chk("win_flag", int'(gif.game_won), 1);

        step(0, 1, 0, 0, 0);
        serve_through();
        hits(37);
        step(0, 0, 0, 0, 1);
        serve_through();
        chk("pre_rst_tens", int'(gif.score_tens), 3);
        step(1, 0, 1, 1, 1);
        chk("midrst_state", int'(gif.state), 0);
        chk("midrst_tens", int'(gif.score_tens), 0);
        chk("midrst_lives", int'(gif.lives), 3);
        chk("midrst_speed", int'(gif.ball_speed), 0);
        chk("midrst_pulse", int'(gif.ball_reset), 0);

        for (int i = 0; i < 20000; i++) begin
            step(($urandom_range(0, 2999) == 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
